// File: rtl/sys_cmd_master.sv
// rtl/sys_cmd_master.sv - host-side UART command initiator: frames a request to TX, collects the response from RX
// Optional response watchdog enabled by defining SYS_CMD_MASTER_TIMEOUT_EN.
module sys_cmd_master #(
  parameter int D_WIDTH        = 8,
  parameter int ADDRESS        = 4,
  parameter int FUNC_ALU       = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CMD_VALID,
  output logic                 CMD_READY,
  input  logic [1:0]           CMD_TYPE,
  input  logic [ADDRESS-1:0]   CMD_ADDR,
  input  logic [D_WIDTH-1:0]   CMD_WDATA,
  input  logic [D_WIDTH-1:0]   CMD_OP_A,
  input  logic [D_WIDTH-1:0]   CMD_OP_B,
  input  logic [FUNC_ALU-1:0]  CMD_FUNC,
  output logic [D_WIDTH-1:0]   TX_P_DATA,
  output logic                 TX_D_VLD,
  input  logic                 TX_READY,
  input  logic [D_WIDTH-1:0]   RX_P_DATA,
  input  logic                 RX_D_VLD,
  output logic [2*D_WIDTH-1:0] RSP_DATA,
  output logic                 RSP_VALID,
  output logic                 RSP_TIMEOUT
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT0, WAIT1} state_t;

  localparam logic [1:0] CT_WR  = 2'd0;
  localparam logic [1:0] CT_RD  = 2'd1;
  localparam logic [1:0] CT_ALU = 2'd2;
  localparam logic [1:0] CT_NOP = 2'd3;

  state_t                 state_q;
  logic [1:0]             bi_q;
  logic [1:0]             bi_d;
  logic [1:0]             type_q;
  logic [ADDRESS-1:0]     addr_q;
  logic [D_WIDTH-1:0]     wdata_q;
  logic [D_WIDTH-1:0]     op_a_q;
  logic [D_WIDTH-1:0]     op_b_q;
  logic [FUNC_ALU-1:0]    func_q;
  logic [D_WIDTH-1:0]     tx_data_q;
  logic                   tx_vld_q;
  logic [2*D_WIDTH-1:0]   rsp_data_q;
  logic                   rsp_valid_q;

  // Byte at index bi of the frame for command type ct.
  function automatic logic [D_WIDTH-1:0] frame_byte(
    input logic [1:0]          ct,
    input logic [1:0]          bi,
    input logic [ADDRESS-1:0]  addr,
    input logic [D_WIDTH-1:0]  wdata,
    input logic [D_WIDTH-1:0]  op_a,
    input logic [D_WIDTH-1:0]  op_b,
    input logic [FUNC_ALU-1:0] func
  );
    logic [D_WIDTH-1:0] addr_x;
    logic [D_WIDTH-1:0] func_x;
    logic [D_WIDTH-1:0] b;
    addr_x = D_WIDTH'(addr);
    func_x = D_WIDTH'(func);
    b      = '0;
    case (ct)
      CT_WR: begin
        case (bi)
          2'd0:    b = D_WIDTH'(8'hAA);
          2'd1:    b = addr_x;
          default: b = wdata;
        endcase
      end
      CT_RD: begin
        b = (bi == 2'd0) ? D_WIDTH'(8'hBB) : addr_x;
      end
      CT_ALU: begin
        case (bi)
          2'd0:    b = D_WIDTH'(8'hCC);
          2'd1:    b = op_a;
          2'd2:    b = op_b;
          default: b = func_x;
        endcase
      end
      default: begin
        b = (bi == 2'd0) ? D_WIDTH'(8'hDD) : func_x;
      end
    endcase
    return b;
  endfunction

  function automatic logic [1:0] last_bi(input logic [1:0] ct);
    case (ct)
      CT_WR:   return 2'd2;
      CT_ALU:  return 2'd3;
      default: return 2'd1;
    endcase
  endfunction

  assign bi_d = bi_q + 2'd1;

`ifdef SYS_CMD_MASTER_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wd_cnt_q;
  logic        rsp_timeout_q;
  logic        wd_expired;

  assign wd_expired  = (wd_cnt_q == WD_LAST);
  assign RSP_TIMEOUT = rsp_timeout_q;
`else
  assign RSP_TIMEOUT = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      bi_q        <= 2'd0;
      type_q      <= CT_WR;
      addr_q      <= '0;
      wdata_q     <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      func_q      <= '0;
      tx_data_q   <= '0;
      tx_vld_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
`ifdef SYS_CMD_MASTER_TIMEOUT_EN
      wd_cnt_q      <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
`ifdef SYS_CMD_MASTER_TIMEOUT_EN
      rsp_timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (CMD_VALID) begin
            type_q    <= CMD_TYPE;
            addr_q    <= CMD_ADDR;
            wdata_q   <= CMD_WDATA;
            op_a_q    <= CMD_OP_A;
            op_b_q    <= CMD_OP_B;
            func_q    <= CMD_FUNC;
            bi_q      <= 2'd0;
            tx_data_q <= frame_byte(CMD_TYPE, 2'd0, CMD_ADDR, CMD_WDATA,
                                    CMD_OP_A, CMD_OP_B, CMD_FUNC);
            tx_vld_q  <= 1'b1;
            state_q   <= SEND;
          end
        end
        SEND: begin
          if (TX_READY) begin
            if (bi_q == last_bi(type_q)) begin
              tx_vld_q <= 1'b0;
              state_q  <= (type_q == CT_WR) ? IDLE : WAIT0;
`ifdef SYS_CMD_MASTER_TIMEOUT_EN
              wd_cnt_q <= '0;
`endif
            end else begin
              bi_q      <= bi_d;
              tx_data_q <= frame_byte(type_q, bi_d, addr_q, wdata_q,
                                      op_a_q, op_b_q, func_q);
            end
          end
        end
        WAIT0: begin
          if (RX_D_VLD) begin
            rsp_data_q[D_WIDTH-1:0] <= RX_P_DATA;
            if (type_q == CT_RD) begin
              rsp_data_q[2*D_WIDTH-1:D_WIDTH] <= '0;
              rsp_valid_q <= 1'b1;
              state_q     <= IDLE;
            end else begin
              state_q <= WAIT1;
            end
`ifdef SYS_CMD_MASTER_TIMEOUT_EN
            wd_cnt_q <= '0;
          end else if (wd_expired) begin
            rsp_timeout_q <= 1'b1;
            state_q       <= IDLE;
          end else begin
            wd_cnt_q <= wd_cnt_q + 16'd1;
`endif
          end
        end
        WAIT1: begin
          if (RX_D_VLD) begin
            rsp_data_q[2*D_WIDTH-1:D_WIDTH] <= RX_P_DATA;
            rsp_valid_q <= 1'b1;
            state_q     <= IDLE;
`ifdef SYS_CMD_MASTER_TIMEOUT_EN
            wd_cnt_q <= '0;
          end else if (wd_expired) begin
            rsp_timeout_q <= 1'b1;
            state_q       <= IDLE;
          end else begin
            wd_cnt_q <= wd_cnt_q + 16'd1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign CMD_READY = (state_q == IDLE);
  assign TX_P_DATA = tx_data_q;
  assign TX_D_VLD  = tx_vld_q;
  assign RSP_DATA  = rsp_data_q;
  assign RSP_VALID = rsp_valid_q;

endmodule

// File: tb/tb_sys_cmd_master.sv
// tb/tb_sys_cmd_master.sv - directed self-checking bench for sys_cmd_master
module tb_sys_cmd_master;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic [1:0]  CMD_TYPE = 2'd0;
  logic [3:0]  CMD_ADDR = 4'd0;
  logic [7:0]  CMD_WDATA = 8'd0;
  logic [7:0]  CMD_OP_A = 8'd0;
  logic [7:0]  CMD_OP_B = 8'd0;
  logic [3:0]  CMD_FUNC = 4'd0;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        TX_READY = 1'b0;
  logic [7:0]  RX_P_DATA = 8'd0;
  logic        RX_D_VLD = 1'b0;
  logic [15:0] RSP_DATA;
  logic        RSP_VALID;
  logic        RSP_TIMEOUT;

  int errors = 0;
  int checks = 0;
  int cyc;
  logic [15:0] last_rsp;

  always #5 CLK = ~CLK;

  sys_cmd_master #(
    .D_WIDTH(8), .ADDRESS(4), .FUNC_ALU(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_TYPE(CMD_TYPE),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_OP_A(CMD_OP_A),
    .CMD_OP_B(CMD_OP_B), .CMD_FUNC(CMD_FUNC),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_READY(TX_READY),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RSP_DATA(RSP_DATA), .RSP_VALID(RSP_VALID), .RSP_TIMEOUT(RSP_TIMEOUT)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Present a command for one accept edge, then scramble the fields.
  task automatic issue(input logic [1:0] t, input logic [3:0] ad, input logic [7:0] wd,
                       input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    CMD_TYPE  = t;
    CMD_ADDR  = ad;
    CMD_WDATA = wd;
    CMD_OP_A  = a;
    CMD_OP_B  = b;
    CMD_FUNC  = f;
    CMD_VALID = 1'b1;
    chk("cmd_ready_at_issue", {31'd0, CMD_READY}, 32'd1);
    tick;
    CMD_VALID = 1'b0;
    CMD_TYPE  = ~t;
    CMD_ADDR  = ~ad;
    CMD_WDATA = ~wd;
    CMD_OP_A  = ~a;
    CMD_OP_B  = ~b;
    CMD_FUNC  = ~f;
  endtask

  // bytes holds frame byte 0 in [7:0]; stall=1 withholds TX_READY every other cycle.
  task automatic run_frame(input logic [31:0] bytes, input int n, input bit stall,
                           output int cycles);
    int idx;
    logic [31:0] bv;
    idx    = 0;
    cycles = 0;
    bv     = bytes;
    while (idx < n && cycles < 20) begin
      TX_READY = stall ? cycles[0] : 1'b1;
      chk("tx_vld", {31'd0, TX_D_VLD}, 32'd1);
      chk("tx_byte", {24'd0, TX_P_DATA}, {24'd0, bv[8*idx +: 8]});
      chk("busy_in_send", {31'd0, CMD_READY}, 32'd0);
      tick;
      if (TX_READY) idx++;
      cycles++;
    end
    TX_READY = 1'b0;
    chk("frame_done", idx, n);
    chk("tx_idle_after", {31'd0, TX_D_VLD}, 32'd0);
  endtask

  task automatic rx(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    tick;
    RX_D_VLD  = 1'b0;
    RX_P_DATA = 8'hEE;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    tick;
    tick;
    chk("rst_tx_vld", {31'd0, TX_D_VLD}, 32'd0);
    chk("rst_tx_data", {24'd0, TX_P_DATA}, 32'd0);
    chk("rst_rsp_data", {16'd0, RSP_DATA}, 32'd0);
    chk("rst_rsp_valid", {31'd0, RSP_VALID}, 32'd0);
    chk("rst_rsp_timeout", {31'd0, RSP_TIMEOUT}, 32'd0);
    chk("rst_cmd_ready", {31'd0, CMD_READY}, 32'd1);
    RST = 1'b1;
    tick;

    // WR addr=5 data=3C, back-to-back bytes
    issue(2'd0, 4'd5, 8'h3C, 8'h00, 8'h00, 4'd0);
    run_frame(32'h003C05AA, 3, 1'b0, cyc);
    chk("wr_cycles", cyc, 3);
    chk("wr_ready_after", {31'd0, CMD_READY}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("wr_no_rsp", {31'd0, RSP_VALID}, 32'd0);
      tick;
    end

    // ALU_OP A=14 B=03 FUNC=2
    issue(2'd2, 4'd0, 8'h00, 8'h14, 8'h03, 4'd2);
    run_frame(32'h020314CC, 4, 1'b0, cyc);
    chk("alu_cycles", cyc, 4);
    rx(8'h3C);
    chk("alu_mid_valid", {31'd0, RSP_VALID}, 32'd0);
    chk("alu_mid_ready", {31'd0, CMD_READY}, 32'd0);
    rx(8'h00);
    chk("alu_rsp_valid", {31'd0, RSP_VALID}, 32'd1);
    chk("alu_rsp_data", {16'd0, RSP_DATA}, 32'h003C);
    chk("alu_rsp_ready", {31'd0, CMD_READY}, 32'd1);
    tick;
    chk("alu_rsp_pulse", {31'd0, RSP_VALID}, 32'd0);

    // ALU_NOP FUNC=1 with TX_READY stalling
    issue(2'd3, 4'd0, 8'h00, 8'h00, 8'h00, 4'd1);
    run_frame(32'h000001DD, 2, 1'b1, cyc);
    chk("nop_stall_cycles", cyc, 4);
    rx(8'h34);
    rx(8'h12);
    chk("nop_rsp_valid", {31'd0, RSP_VALID}, 32'd1);
    chk("nop_rsp_data", {16'd0, RSP_DATA}, 32'h1234);

    // RD addr=2 accepted in the RSP_VALID cycle
    issue(2'd1, 4'd2, 8'h00, 8'h00, 8'h00, 4'd0);
    run_frame(32'h000002BB, 2, 1'b0, cyc);
    CMD_VALID = 1'b1;
    CMD_TYPE  = 2'd0;
    for (int i = 0; i < 3; i++) begin
      chk("wait_not_ready", {31'd0, CMD_READY}, 32'd0);
      chk("wait_no_tx", {31'd0, TX_D_VLD}, 32'd0);
      chk("wait_no_rsp", {31'd0, RSP_VALID}, 32'd0);
      tick;
    end
    CMD_VALID = 1'b0;
    rx(8'h7E);
    chk("rd_rsp_valid", {31'd0, RSP_VALID}, 32'd1);
    chk("rd_rsp_data", {16'd0, RSP_DATA}, 32'h007E);
    tick;
    chk("rd_rsp_pulse", {31'd0, RSP_VALID}, 32'd0);
    chk("rd_rsp_held", {16'd0, RSP_DATA}, 32'h007E);
    chk("rd_no_tx_after", {31'd0, TX_D_VLD}, 32'd0);

    // RD with no response
    issue(2'd1, 4'd9, 8'h00, 8'h00, 8'h00, 4'd0);
    run_frame(32'h000009BB, 2, 1'b0, cyc);
`ifdef SYS_CMD_MASTER_TIMEOUT_EN
    cyc = 0;
    while (!RSP_TIMEOUT && cyc < 40) begin
      tick;
      cyc++;
    end
    chk("timeout_latency", cyc, 16);
    chk("timeout_ready", {31'd0, CMD_READY}, 32'd1);
    chk("timeout_no_valid", {31'd0, RSP_VALID}, 32'd0);
    tick;
    chk("timeout_pulse", {31'd0, RSP_TIMEOUT}, 32'd0);
    last_rsp = 16'h007E;
`else
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      if (RSP_TIMEOUT !== 1'b0) cyc++;
      tick;
    end
    chk("no_timeout_seen", cyc, 0);
    chk("still_waiting", {31'd0, CMD_READY}, 32'd0);
    rx(8'hA5);
    chk("late_rsp_valid", {31'd0, RSP_VALID}, 32'd1);
    chk("late_rsp_data", {16'd0, RSP_DATA}, 32'h00A5);
    tick;
    last_rsp = 16'h00A5;
`endif

    // Stray RX in IDLE is dropped
    rx(8'h55);
    chk("stray_no_valid", {31'd0, RSP_VALID}, 32'd0);
    chk("stray_ready", {31'd0, CMD_READY}, 32'd1);
    chk("stray_data_kept", {16'd0, RSP_DATA}, {16'd0, last_rsp});
    chk("stray_no_tx", {31'd0, TX_D_VLD}, 32'd0);

    // Reset in the middle of an ALU frame
    issue(2'd2, 4'd0, 8'h00, 8'h61, 8'h62, 4'd7);
    TX_READY = 1'b1;
    tick;
    TX_READY = 1'b0;
    chk("mid_frame_byte", {24'd0, TX_P_DATA}, 32'h61);
    #2;
    RST = 1'b0;
    #1;
    chk("async_tx_vld", {31'd0, TX_D_VLD}, 32'd0);
    chk("async_tx_data", {24'd0, TX_P_DATA}, 32'd0);
    chk("async_rsp_data", {16'd0, RSP_DATA}, 32'd0);
    chk("async_ready", {31'd0, CMD_READY}, 32'd1);
    tick;
    RST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("post_rst_tx_vld", {31'd0, TX_D_VLD}, 32'd0);
      chk("post_rst_valid", {31'd0, RSP_VALID}, 32'd0);
      chk("post_rst_timeout", {31'd0, RSP_TIMEOUT}, 32'd0);
      chk("post_rst_ready", {31'd0, CMD_READY}, 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
